projectile_pool: RTL and testbench

// - Parametrised pool of SLOT_COUNT projectiles: spawn, per-frame motion, off-screen retire, hit retire.
// - Replaces the fixed player-only bullet controller; one instance per shooter class.
//   DIR_UP=1 is the player pool. DIR_UP=0 is an enemy pool.
// - Outputs flat x/y/active buses for the sprite drawers and collision controllers.
// - Outputs a spawn pulse for the sound block.

---
 rtl/projectile_pool_pkg.sv | 13 +
 rtl/projectile_pool_lowest_free_slot.sv | 26 ++
 rtl/projectile_pool.sv | 137 +++++++++++++
 tb/tb_projectile_pool.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/projectile_pool_pkg.sv
// Shared game constants and the helper that sizes slot-index buses.
package projectile_pool_pkg;

  localparam int GAME_COORD_W  = 10;
  localparam int GAME_SCREEN_H = 480;
  localparam bit TRAVEL_UP     = 1'b1;

  // Index width that stays legal for a single-slot pool.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/projectile_pool_lowest_free_slot.sv
// Combinational priority encoder: index of the lowest set bit of free_mask.
module projectile_pool_lowest_free_slot
  import projectile_pool_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]              free_mask,
  output logic [idx_width(N)-1:0]   idx,
  output logic                      any_free
);

  localparam int IW = idx_width(N);

  // Scan from the top down so the lowest free index is written last.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        idx      = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// Pool of projectile slots: spawn on frame ticks, per-frame motion, off-screen and hit retire.
module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter int SLOT_COUNT      = 8,
  parameter int COORD_W         = GAME_COORD_W,
  parameter int SPEED           = 4,
  parameter bit DIR_UP          = TRAVEL_UP,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SCREEN_H        = GAME_SCREEN_H,
  parameter int SPAWN_DX        = 12,
  parameter int SPAWN_DY        = 8
) (
  input  logic                            clk25,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            fire,
  input  logic [COORD_W-1:0]              origin_x,
  input  logic [COORD_W-1:0]              origin_y,
  input  logic [SLOT_COUNT-1:0]           hit_flat,
  output logic [COORD_W*SLOT_COUNT-1:0]   x_flat,
  output logic [COORD_W*SLOT_COUNT-1:0]   y_flat,
  output logic [SLOT_COUNT-1:0]           active_flat,
  output logic                            spawn_pulse,
  output logic [$clog2(SLOT_COUNT+1)-1:0] free_count
);

  localparam int IW = idx_width(SLOT_COUNT);
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int FW = $clog2(SLOT_COUNT + 1);
  localparam logic [COORD_W:0] SPEED_W    = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0] SCREEN_H_W = (COORD_W+1)'(SCREEN_H);
  localparam logic [COORD_W:0] SPAWN_DY_W = (COORD_W+1)'(SPAWN_DY);

  logic [SLOT_COUNT-1:0] active_vec;
  logic [CW-1:0]         cooldown_reg, cooldown_next;
  logic                  spawn_pulse_reg;
  logic [IW-1:0]         free_idx;
  logic                  any_free;
  logic                  spawn_ok, spawn_blocked;
  logic [COORD_W-1:0]    spawn_x, spawn_y;

  projectile_pool_lowest_free_slot #(.N(SLOT_COUNT)) u_free (
    .free_mask (~active_vec),
    .idx       (free_idx),
    .any_free  (any_free)
  );

  // An upward shot from too close to the top edge would wrap, so it is dropped.
  always_comb begin
    spawn_x = origin_x + COORD_W'(SPAWN_DX);
    if (DIR_UP) begin
      spawn_y       = origin_y - COORD_W'(SPAWN_DY);
      spawn_blocked = ({1'b0, origin_y} < SPAWN_DY_W);
    end else begin
      spawn_y       = origin_y + COORD_W'(SPAWN_DY);
      spawn_blocked = 1'b0;
    end
    spawn_ok = frame_tick && fire && (cooldown_reg == '0) && any_free && !spawn_blocked;
  end

  always_comb begin
    cooldown_next = cooldown_reg;
    if (spawn_ok)
      cooldown_next = CW'(COOLDOWN_FRAMES);
    else if (frame_tick && (cooldown_reg != '0))
      cooldown_next = cooldown_reg - 1'b1;
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      cooldown_reg    <= '0;
      spawn_pulse_reg <= 1'b0;
    end else begin
      cooldown_reg    <= cooldown_next;
      spawn_pulse_reg <= spawn_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLOT_COUNT; gi++) begin : g_slot
      logic [COORD_W-1:0] x_reg, y_reg, x_next, y_next, y_moved;
      logic               active_reg, active_next, off_screen;

      // Hit beats motion; a spawn target is always inactive so it never moves on its spawn tick.
      always_comb begin
        if (DIR_UP) begin
          off_screen = ({1'b0, y_reg} < SPEED_W);
          y_moved    = y_reg - COORD_W'(SPEED);
        end else begin
          off_screen = (({1'b0, y_reg} + SPEED_W) >= SCREEN_H_W);
          y_moved    = y_reg + COORD_W'(SPEED);
        end
        x_next      = x_reg;
        y_next      = y_reg;
        active_next = active_reg;
        if (hit_flat[gi] && active_reg) begin
          active_next = 1'b0;
        end else if (frame_tick && active_reg) begin
          if (off_screen) active_next = 1'b0;
          else            y_next      = y_moved;
        end else if (spawn_ok && (free_idx == IW'(gi))) begin
          x_next      = spawn_x;
          y_next      = spawn_y;
          active_next = 1'b1;
        end
      end

      always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
          x_reg      <= '0;
          y_reg      <= '0;
          active_reg <= 1'b0;
        end else begin
          x_reg      <= x_next;
          y_reg      <= y_next;
          active_reg <= active_next;
        end
      end

      assign active_vec[gi]                   = active_reg;
      assign x_flat[gi*COORD_W +: COORD_W]    = x_reg;
      assign y_flat[gi*COORD_W +: COORD_W]    = y_reg;
    end
  endgenerate

  always_comb begin
    free_count = '0;
    for (int i = 0; i < SLOT_COUNT; i++)
      if (!active_vec[i]) free_count = free_count + 1'b1;
  end

  assign active_flat = active_vec;
  assign spawn_pulse = spawn_pulse_reg;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench: an upward player pool (defaults) and a small downward enemy pool.
module tb_projectile_pool;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic        reset;
  logic        ft_a, fire_a;
  logic [9:0]  ox_a, oy_a;
  logic [7:0]  hit_a, act_a;
  logic [79:0] x_a, y_a;
  logic        sp_a;
  logic [3:0]  fc_a;

  logic        ft_b, fire_b;
  logic [9:0]  ox_b, oy_b;
  logic [3:0]  hit_b, act_b;
  logic [39:0] x_b, y_b;
  logic        sp_b;
  logic [2:0]  fc_b;

  int checks = 0;
  int errors = 0;

  projectile_pool dut_a (
    .clk25(clk25), .reset(reset), .frame_tick(ft_a), .fire(fire_a),
    .origin_x(ox_a), .origin_y(oy_a), .hit_flat(hit_a),
    .x_flat(x_a), .y_flat(y_a), .active_flat(act_a),
    .spawn_pulse(sp_a), .free_count(fc_a)
  );

  projectile_pool #(.SLOT_COUNT(4), .DIR_UP(1'b0), .COOLDOWN_FRAMES(0)) dut_b (
    .clk25(clk25), .reset(reset), .frame_tick(ft_b), .fire(fire_b),
    .origin_x(ox_b), .origin_y(oy_b), .hit_flat(hit_b),
    .x_flat(x_b), .y_flat(y_b), .active_flat(act_b),
    .spawn_pulse(sp_b), .free_count(fc_b)
  );

  function automatic logic [9:0] xa(input int s); return x_a[s*10 +: 10]; endfunction
  function automatic logic [9:0] ya(input int s); return y_a[s*10 +: 10]; endfunction
  function automatic logic [9:0] xb(input int s); return x_b[s*10 +: 10]; endfunction
  function automatic logic [9:0] yb(input int s); return y_b[s*10 +: 10]; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc_a(input bit ft, input bit f, input logic [7:0] h);
    @(negedge clk25);
    ft_a = ft; fire_a = f; hit_a = h;
    @(posedge clk25); #1;
  endtask

  task automatic cyc_b(input bit ft, input bit f);
    @(negedge clk25);
    ft_b = ft; fire_b = f;
    @(posedge clk25); #1;
  endtask

  initial begin
    reset = 1'b1;
    ft_a = 0; fire_a = 0; hit_a = '0; ox_a = 10'd280; oy_a = 10'd400;
    ft_b = 0; fire_b = 0; hit_b = '0; ox_b = 10'd50;  oy_b = 10'd468;
    #12;
    check("rst_free", fc_a, 8);
    check("rst_active", act_a, 0);
    check("rst_pulse", sp_a, 0);
    check("rst_y0", ya(0), 0);
    @(negedge clk25) reset = 1'b0;

    cyc_a(0, 1, 0);
    $display("step fire_no_tick active=%0h", act_a);
    check("fire_no_tick", act_a, 0);

    cyc_a(1, 1, 0);
    $display("step tick0 active=%0h x0=%0d y0=%0d pulse=%0b free=%0d", act_a, xa(0), ya(0), sp_a, fc_a);
    check("t0_active", act_a, 1);
    check("t0_x0", xa(0), 292);
    check("t0_y0", ya(0), 392);
    check("t0_pulse", sp_a, 1);
    check("t0_free", fc_a, 7);
    cyc_a(0, 1, 0);
    check("t0_pulse_drop", sp_a, 0);
    check("t0_y0_hold", ya(0), 392);

    for (int t = 1; t <= 19; t++) begin
      cyc_a(1, 1, 0);
      $display("step hold tick%0d active=%0h pulse=%0b", t, act_a, sp_a);
      check("hold_pulse", sp_a, (t == 9 || t == 18) ? 1 : 0);
      if (t == 18) begin
        check("t18_y0", ya(0), 320);
        check("t18_y1", ya(1), 356);
        check("t18_y2", ya(2), 392);
        check("t18_active", act_a, 7);
      end
    end
    check("t19_free", fc_a, 5);
    cyc_a(0, 0, 0);

    @(negedge clk25); #2 reset = 1'b1; #1;
    $display("step midframe_reset active=%0h free=%0d", act_a, fc_a);
    check("mid_rst_active", act_a, 0);
    check("mid_rst_free", fc_a, 8);
    check("mid_rst_y0", ya(0), 0);
    @(negedge clk25) reset = 1'b0;

    for (int t = 0; t <= 63; t++) begin
      cyc_a(1, 1, 0);
      if (t == 0) check("post_rst_slot0", act_a, 1);
    end
    $display("step filled active=%0h free=%0d", act_a, fc_a);
    check("fill_active", act_a, 8'hFF);
    check("fill_free", fc_a, 0);
    check("fill_y0", ya(0), 140);
    check("fill_y7", ya(7), 392);
    for (int t = 64; t <= 71; t++) cyc_a(1, 0, 0);
    cyc_a(1, 1, 0);
    $display("step full_fire active=%0h pulse=%0b", act_a, sp_a);
    check("full_no_pulse", sp_a, 0);
    check("full_active", act_a, 8'hFF);
    check("full_y2", ya(2), 176);
    cyc_a(0, 0, 8'h04);
    check("hit2_active", act_a, 8'hFB);
    check("hit2_free", fc_a, 1);
    check("hit2_y_hold", ya(2), 176);
    cyc_a(1, 1, 0);
    $display("step respawn active=%0h x2=%0d y2=%0d pulse=%0b", act_a, xa(2), ya(2), sp_a);
    check("respawn_active", act_a, 8'hFF);
    check("respawn_pulse", sp_a, 1);
    check("respawn_y2", ya(2), 392);
    check("respawn_x2", xa(2), 292);
    check("respawn_y0", ya(0), 100);

    cyc_a(1, 0, 8'h02);
    $display("step hit_and_tick active=%0h y1=%0d y0=%0d", act_a, ya(1), ya(0));
    check("hit_tick_active", act_a, 8'hFD);
    check("hit_tick_y1", ya(1), 136);
    check("hit_tick_y0", ya(0), 96);
    cyc_a(0, 0, 8'h02);
    check("hit_inactive_act", act_a, 8'hFD);
    check("hit_inactive_y1", ya(1), 136);

    @(negedge clk25) reset = 1'b1;
    @(negedge clk25) reset = 1'b0;
    ox_a = 10'd100; oy_a = 10'd11;
    cyc_a(1, 1, 0);
    check("low_spawn_y0", ya(0), 3);
    check("low_spawn_x0", xa(0), 112);
    cyc_a(1, 0, 0);
    $display("step top_retire active=%0h y0=%0d", act_a, ya(0));
    check("top_retire_act", act_a, 0);
    check("top_retire_y0", ya(0), 3);
    check("top_retire_x0", xa(0), 112);
    check("top_retire_free", fc_a, 8);
    for (int t = 0; t < 7; t++) cyc_a(1, 0, 0);
    oy_a = 10'd7;
    cyc_a(1, 1, 0);
    check("suppress_act", act_a, 0);
    check("suppress_pulse", sp_a, 0);
    oy_a = 10'd8;
    cyc_a(1, 1, 0);
    $display("step edge_spawn active=%0h y0=%0d pulse=%0b", act_a, ya(0), sp_a);
    check("edge_spawn_act", act_a, 1);
    check("edge_spawn_y0", ya(0), 0);
    check("edge_spawn_pulse", sp_a, 1);
    cyc_a(1, 0, 0);
    check("edge_retire_act", act_a, 0);

    cyc_b(1, 1);
    $display("step down_spawn active=%0h x0=%0d y0=%0d", act_b, xb(0), yb(0));
    check("dn_spawn_act", act_b, 1);
    check("dn_spawn_x0", xb(0), 62);
    check("dn_spawn_y0", yb(0), 476);
    check("dn_spawn_pulse", sp_b, 1);
    oy_b = 10'd467;
    cyc_b(1, 1);
    $display("step down_476 active=%0h y0=%0d y1=%0d", act_b, yb(0), yb(1));
    check("dn_476_act", act_b, 2);
    check("dn_476_y0", yb(0), 476);
    check("dn_475_y1", yb(1), 475);
    check("dn_back2back_pulse", sp_b, 1);
    cyc_b(1, 0);
    check("dn_479_act", act_b, 2);
    check("dn_479_y1", yb(1), 479);
    check("dn_479_pulse", sp_b, 0);
    cyc_b(1, 0);
    check("dn_483_act", act_b, 0);
    check("dn_483_free", fc_b, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
